// File: rtl/regfile_wb_scoreboard.sv
// Busy scoreboard for the int/fp register files: RAW/WAW issue stall and the shared write port (pwb vs lwb, anti-starvation).
// Grants and rf_* are zero-latency; busy bits and busy_count update at the edge; AXI_stall freezes everything. Option: SCOREBOARD_FWD_EN.
module regfile_wb_scoreboard #(
    parameter int NREG     = 32,
    parameter int MAX_WAIT = 4,
    localparam int AW = $clog2(NREG),
    localparam int WW = $clog2(MAX_WAIT + 1),
    localparam int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          AXI_stall,

    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rs1,
    input  logic [AW-1:0] iss_rs2,
    input  logic          iss_rs1_fp,
    input  logic          iss_rs2_fp,
    input  logic          iss_rs1_use,
    input  logic          iss_rs2_use,
    input  logic [AW-1:0] iss_rd,
    input  logic          iss_rd_fp,
    input  logic          iss_rd_we,
    input  logic          iss_long,
    output logic          iss_stall,

    input  logic          pwb_valid,
    output logic          pwb_ready,
    input  logic [AW-1:0] pwb_addr,
    input  logic          pwb_fp,
    input  logic [31:0]   pwb_data,

    input  logic          lwb_valid,
    output logic          lwb_ready,
    input  logic [AW-1:0] lwb_addr,
    input  logic          lwb_fp,
    input  logic [31:0]   lwb_data,

    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic          rf_wfp,
    output logic [31:0]   rf_wdata,
    output logic [CW-1:0] busy_count
);

    typedef struct packed {
        logic          fp;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wb_t;

    logic [NREG-1:0] busy_int, busy_fp;
    logic [NREG-1:0] busy_int_nxt, busy_fp_nxt;
    logic [NREG-1:0] chk_int, chk_fp;
    logic [NREG-1:0] clr_int, clr_fp;
    logic [NREG-1:0] set_int, set_fp;
    logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
    logic [CW-1:0]   busy_count_nxt;

    logic lwb_prio;
    logic pwb_gnt, lwb_gnt;
    logic raw1, raw2, waw;
    logic accept;
    wb_t  pwb_req, lwb_req, wsel;

    assign pwb_req = '{fp: pwb_fp, addr: pwb_addr, data: pwb_data};
    assign lwb_req = '{fp: lwb_fp, addr: lwb_addr, data: lwb_data};

    // Once lwb has lost MAX_WAIT times it outranks the pipeline writeback.
    assign lwb_prio = (wait_cnt == WW'(MAX_WAIT));

    always_comb begin
        pwb_gnt = 1'b0;
        lwb_gnt = 1'b0;
        if (!AXI_stall) begin
            if (lwb_valid && (lwb_prio || !pwb_valid)) begin
                lwb_gnt = 1'b1;
            end else if (pwb_valid) begin
                pwb_gnt = 1'b1;
            end
        end
    end

    assign pwb_ready = pwb_gnt;
    assign lwb_ready = lwb_gnt;

    always_comb begin
        wsel = '0;
        if (lwb_gnt) begin
            wsel = lwb_req;
        end else if (pwb_gnt) begin
            wsel = pwb_req;
        end
    end

    assign rf_waddr = wsel.addr;
    assign rf_wfp   = wsel.fp;
    assign rf_wdata = wsel.data;
    assign rf_we    = (pwb_gnt | lwb_gnt) & (wsel.fp | (wsel.addr != '0));

    assign clr_int = (lwb_gnt && !lwb_fp) ? (NREG'(1) << lwb_addr) : '0;
    assign clr_fp  = (lwb_gnt &&  lwb_fp) ? (NREG'(1) << lwb_addr) : '0;

`ifdef SCOREBOARD_FWD_EN
    // The RF is write-before-read, so a register retiring this cycle is already readable.
    assign chk_int = busy_int & ~clr_int;
    assign chk_fp  = busy_fp  & ~clr_fp;
`else
    assign chk_int = busy_int;
    assign chk_fp  = busy_fp;
`endif

    assign raw1 = iss_rs1_use & (iss_rs1_fp ? chk_fp[iss_rs1] : chk_int[iss_rs1]);
    assign raw2 = iss_rs2_use & (iss_rs2_fp ? chk_fp[iss_rs2] : chk_int[iss_rs2]);
    assign waw  = iss_rd_we   & (iss_rd_fp  ? chk_fp[iss_rd]  : chk_int[iss_rd]);

    assign iss_stall = iss_valid & (raw1 | raw2 | waw | AXI_stall);
    assign accept    = iss_valid & ~iss_stall & iss_rd_we & iss_long
                     & (iss_rd_fp | (iss_rd != '0));

    assign set_int = (accept && !iss_rd_fp) ? (NREG'(1) << iss_rd) : '0;
    assign set_fp  = (accept &&  iss_rd_fp) ? (NREG'(1) << iss_rd) : '0;

    // Set is applied after clear so a same-edge set wins; int x0 is pinned to zero.
    assign busy_int_nxt = ((busy_int & ~clr_int) | set_int) & ~NREG'(1);
    assign busy_fp_nxt  = (busy_fp & ~clr_fp) | set_fp;

    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!AXI_stall) begin
            if (lwb_gnt) begin
                wait_cnt_nxt = '0;
            end else if (lwb_valid && !lwb_prio) begin
                wait_cnt_nxt = wait_cnt + WW'(1);
            end
        end
    end

    always_comb begin
        busy_count_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_count_nxt = busy_count_nxt + CW'(busy_int_nxt[i]) + CW'(busy_fp_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_int   <= '0;
            busy_fp    <= '0;
            wait_cnt   <= '0;
            busy_count <= '0;
        end else begin
            busy_int   <= busy_int_nxt;
            busy_fp    <= busy_fp_nxt;
            wait_cnt   <= wait_cnt_nxt;
            busy_count <= busy_count_nxt;
        end
    end

    // A long-latency writeback with no pending entry means the producer lost track of its result.
    a_lwb_targets_busy: assert property (
        @(posedge clk) disable iff (rst)
        (lwb_gnt && (lwb_fp || (lwb_addr != '0))) |-> (lwb_fp ? busy_fp[lwb_addr] : busy_int[lwb_addr])
    );

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed scenarios followed by random traffic, all checked against a register-level busy/arbiter model.
module tb_regfile_wb_scoreboard;
    localparam int NREG     = 32;
    localparam int MAX_WAIT = 4;
`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        AXI_stall = 1'b0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic        iss_rs1_fp = 1'b0, iss_rs2_fp = 1'b0, iss_rs1_use = 1'b0, iss_rs2_use = 1'b0;
    logic        iss_rd_fp = 1'b0, iss_rd_we = 1'b0, iss_long = 1'b0;
    logic        iss_stall;
    logic        pwb_valid = 1'b0, pwb_fp = 1'b0, pwb_ready;
    logic [4:0]  pwb_addr = '0;
    logic [31:0] pwb_data = '0;
    logic        lwb_valid = 1'b0, lwb_fp = 1'b0, lwb_ready;
    logic [4:0]  lwb_addr = '0;
    logic [31:0] lwb_data = '0;
    logic        rf_we, rf_wfp;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [6:0]  busy_count;

    always #5 clk = ~clk;

    regfile_wb_scoreboard #(.NREG(NREG), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .AXI_stall(AXI_stall),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rs1_fp(iss_rs1_fp), .iss_rs2_fp(iss_rs2_fp),
        .iss_rs1_use(iss_rs1_use), .iss_rs2_use(iss_rs2_use),
        .iss_rd(iss_rd), .iss_rd_fp(iss_rd_fp), .iss_rd_we(iss_rd_we),
        .iss_long(iss_long), .iss_stall(iss_stall),
        .pwb_valid(pwb_valid), .pwb_ready(pwb_ready), .pwb_addr(pwb_addr),
        .pwb_fp(pwb_fp), .pwb_data(pwb_data),
        .lwb_valid(lwb_valid), .lwb_ready(lwb_ready), .lwb_addr(lwb_addr),
        .lwb_fp(lwb_fp), .lwb_data(lwb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wfp(rf_wfp), .rf_wdata(rf_wdata),
        .busy_count(busy_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: one flag per architectural register plus lwb's losing streak.
    bit busy_m [2][NREG];
    int denied = 0;
    logic o_stall, o_pwb, o_lwb, o_we;

    typedef struct {bit fp; bit [4:0] idx;} ent_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < NREG; r++)
                n += int'(busy_m[f][r]);
        return n;
    endfunction

    function automatic bit hz_busy(input bit fp, input bit [4:0] idx, input bit gl);
        if (!fp && idx == 0) return 1'b0;
        if (FWD && gl && lwb_fp == fp && lwb_addr == idx) return 1'b0;
        return busy_m[fp][idx];
    endfunction

    task automatic model_clear();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < NREG; r++)
                busy_m[f][r] = 1'b0;
        denied = 0;
    endtask

    task automatic cycle(input string tag);
        bit gp, gl, stall, acc, we;
        bit [37:0] wexp;
        @(negedge clk);
        gp = 1'b0;
        gl = 1'b0;
        if (!AXI_stall) begin
            if (denied >= MAX_WAIT && lwb_valid) gl = 1'b1;
            else if (pwb_valid)                  gp = 1'b1;
            else if (lwb_valid)                  gl = 1'b1;
        end
        stall = iss_valid && (AXI_stall
              || (iss_rs1_use && hz_busy(iss_rs1_fp, iss_rs1, gl))
              || (iss_rs2_use && hz_busy(iss_rs2_fp, iss_rs2, gl))
              || (iss_rd_we   && hz_busy(iss_rd_fp,  iss_rd,  gl)));
        wexp = '0;
        if (gl)      wexp = {lwb_fp, lwb_addr, lwb_data};
        else if (gp) wexp = {pwb_fp, pwb_addr, pwb_data};
        we  = (gl || gp) && (wexp[37] || wexp[36:32] != 0);
        acc = iss_valid && !stall && iss_rd_we && iss_long && (iss_rd_fp || iss_rd != 0);
        o_stall = iss_stall;
        o_pwb   = pwb_ready;
        o_lwb   = lwb_ready;
        o_we    = rf_we;
        check({tag, "/iss_stall"}, iss_stall, stall);
        check({tag, "/pwb_ready"}, pwb_ready, gp);
        check({tag, "/lwb_ready"}, lwb_ready, gl);
        check({tag, "/rf_we"}, rf_we, we);
        check({tag, "/rf_write"}, {rf_wfp, rf_waddr, rf_wdata}, wexp);
        @(posedge clk);
        if (!AXI_stall) begin
            if (gl) denied = 0;
            else if (lwb_valid && denied < MAX_WAIT) denied++;
        end
        if (gl)  busy_m[lwb_fp][lwb_addr] = 1'b0;
        if (acc) busy_m[iss_rd_fp][iss_rd] = 1'b1;
        #1;
        check({tag, "/busy_count"}, busy_count, model_count());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check("reset/busy_count", busy_count, 0);
    endtask

    task automatic iss(input bit v, input bit [4:0] rd, input bit rdfp, input bit we, input bit lng,
                       input bit [4:0] rs1, input bit fp1, input bit u1,
                       input bit [4:0] rs2, input bit fp2, input bit u2);
        iss_valid = v;  iss_rd = rd;  iss_rd_fp = rdfp; iss_rd_we = we; iss_long = lng;
        iss_rs1 = rs1;  iss_rs1_fp = fp1; iss_rs1_use = u1;
        iss_rs2 = rs2;  iss_rs2_fp = fp2; iss_rs2_use = u2;
    endtask

    task automatic iss_off();
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pwb(input bit v, input bit [4:0] a, input bit fp, input bit [31:0] d);
        pwb_valid = v; pwb_addr = a; pwb_fp = fp; pwb_data = d;
    endtask

    task automatic lwb(input bit v, input bit [4:0] a, input bit fp, input bit [31:0] d);
        lwb_valid = v; lwb_addr = a; lwb_fp = fp; lwb_data = d;
    endtask

    initial begin
        ent_t q[$];
        ent_t e;
        do_reset();
        cycle("idle");

        // FDIV f3 then dependent FADD on f3
        iss(1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle("t1_issue");
        check("t1_count_set", busy_count, 1);
        iss(1, 4, 1, 1, 0, 3, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("t1_wait");
            check("t1_raw_stall", o_stall, 1);
        end
        lwb(1, 3, 1, 32'hF00D_0003);
        cycle("t1_grant");
        check("t1_lwb_we", o_we, 1);
        lwb(0, 0, 0, 0);
        cycle("t1_after");
        check("t1_no_stall", o_stall, 0);
        check("t1_count_clr", busy_count, 0);
        iss_off();

        // Long write to int x0 never becomes busy
        iss(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle("t2_issue");
        check("t2_count", busy_count, 0);
        iss_off();
        lwb(1, 0, 0, 32'h1234_5678);
        cycle("t2_lwb_x0");
        check("t2_lwb_granted", o_lwb, 1);
        check("t2_no_we", o_we, 0);
        lwb(0, 0, 0, 0);

        // Anti-starvation, twice to show the wait counter restarts
        for (int rep = 0; rep < 2; rep++) begin
            iss(1, 9, 0, 1, 1, 0, 0, 0, 0, 0, 0);
            cycle("t3_issue");
            iss_off();
            pwb(1, 10, 0, 32'hAAAA_0000 + rep);
            lwb(1, 9, 0, 32'h5555_0000 + rep);
            for (int i = 0; i <= MAX_WAIT; i++) begin
                cycle("t3_arb");
                check("t3_pwb_slot", o_pwb, i < MAX_WAIT);
                check("t3_lwb_slot", o_lwb, i == MAX_WAIT);
            end
            lwb(0, 0, 0, 0);
            cycle("t3_pwb_only");
            check("t3_pwb_back", o_pwb, 1);
        end
        pwb(0, 0, 0, 0);

        // WAW on x5
        iss(1, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle("t4_first");
        cycle("t4_waw");
        check("t4_waw_stall", o_stall, 1);
        lwb(1, 5, 0, 32'h0000_0005);
        cycle("t4_grant");
        check("t4_grant_stall", o_stall, !FWD);
        lwb(0, 0, 0, 0);
        if (!FWD) begin
            cycle("t4_accept");
            check("t4_accept_stall", o_stall, 0);
        end
        iss_off();
        cycle("t4_idle");
        check("t4_reset_busy", busy_count, 1);
        lwb(1, 5, 0, 32'h0000_0055);
        cycle("t4_drain");
        lwb(0, 0, 0, 0);

        // AXI freeze, then reset with work pending
        iss(1, 6, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle("t5_issue");
        AXI_stall = 1'b1;
        iss(1, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        pwb(1, 11, 1, 32'hDEAD_BEEF);
        lwb(1, 6, 0, 32'hCAFE_0006);
        for (int i = 0; i < 3; i++) begin
            cycle("t5_frozen");
            check("t5_no_we", o_we, 0);
            check("t5_no_pwb", o_pwb, 0);
            check("t5_no_lwb", o_lwb, 0);
            check("t5_stall", o_stall, 1);
            check("t5_count", busy_count, 1);
        end
        AXI_stall = 1'b0;
        iss_off();
        for (int i = 0; i <= MAX_WAIT; i++) begin
            cycle("t5_thaw");
            check("t5_lwb_slot", o_lwb, i == MAX_WAIT);
        end
        lwb(0, 0, 0, 0);
        pwb(0, 0, 0, 0);
        iss(1, 6, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle("t5_repend");
        iss(1, 12, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle("t5_repend2");
        iss_off();
        check("t5_pending", busy_count, 2);
        do_reset();
        cycle("t5_post_reset");

        // Same-cycle forwarding on f7
        iss(1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle("t6_issue");
        iss(1, 8, 1, 1, 0, 0, 0, 0, 7, 1, 1);
        lwb(1, 7, 1, 32'h0000_0F07);
        cycle("t6_grant");
        check("t6_grant_cycle_stall", o_stall, !FWD);
        lwb(0, 0, 0, 0);
        if (!FWD) begin
            cycle("t6_next");
            check("t6_next_stall", o_stall, 0);
        end
        iss_off();
        cycle("t6_idle");

        // Random traffic; lwb only ever targets a register the model holds busy
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            AXI_stall = ($urandom_range(0, 9) == 0);
            iss($urandom_range(0, 1), 5'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1), 5'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom), 1'($urandom), 1'($urandom));
            pwb($urandom_range(0, 2) == 0, 5'($urandom), 1'($urandom), $urandom);
            q.delete();
            for (int f = 0; f < 2; f++)
                for (int r = 0; r < NREG; r++)
                    if (busy_m[f][r]) begin
                        e.fp = 1'(f);
                        e.idx = 5'(r);
                        q.push_back(e);
                    end
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                e = q[$urandom_range(0, q.size() - 1)];
                lwb(1, e.idx, e.fp, $urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                lwb(1, 0, 0, $urandom);
            end else begin
                lwb(0, 0, 0, 0);
            end
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
